// File: rtl/bsg_axil_packet_packer.sv
// rtl/bsg_axil_packet_packer.sv - AXI-lite slave to narrow request packet packer with in-order response queue
module bsg_axil_packet_packer #(
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter int pkt_addr_width_p = 23,
    parameter int pkt_data_width_p = 8,
    parameter int els_p            = 4,
    localparam int pkt_width_p     = 1 + pkt_addr_width_p + pkt_data_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [axi_addr_width_p-1:0] s_axi_awaddr_i,
    input  logic [2:0]                  s_axi_awprot_i,
    input  logic                        s_axi_awvalid_i,
    output logic                        s_axi_awready_o,

    input  logic [axi_data_width_p-1:0] s_axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] s_axi_wstrb_i,
    input  logic                        s_axi_wvalid_i,
    output logic                        s_axi_wready_o,

    output logic [1:0]                  s_axi_bresp_o,
    output logic                        s_axi_bvalid_o,
    input  logic                        s_axi_bready_i,

    input  logic [axi_addr_width_p-1:0] s_axi_araddr_i,
    input  logic [2:0]                  s_axi_arprot_i,
    input  logic                        s_axi_arvalid_i,
    output logic                        s_axi_arready_o,

    output logic [axi_data_width_p-1:0] s_axi_rdata_o,
    output logic [1:0]                  s_axi_rresp_o,
    output logic                        s_axi_rvalid_o,
    input  logic                        s_axi_rready_i,

    output logic [pkt_width_p-1:0]      data_o,
    output logic                        v_o,
    input  logic                        ready_i,

    input  logic [axi_data_width_p-1:0] data_i,
    input  logic                        v_i,
    output logic                        ready_o
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [1:0] resp_okay   = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;

    // Each entry is {is_write, err}; order of grants is order of responses.
    logic [1:0]       fifo_q [els_p];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             rd_prio_q, rd_prio_d;

    logic wr_cand, rd_cand, sel_rd, sel_wr;
    logic wr_oor, rd_oor, full, nonempty;
    logic wr_grant, rd_grant, push, pop, grant_err;
    logic head_w, head_err, head_rd_ok;

    assign wr_oor  = |(s_axi_awaddr_i >> pkt_addr_width_p);
    assign rd_oor  = |(s_axi_araddr_i >> pkt_addr_width_p);
    assign wr_cand = s_axi_awvalid_i & s_axi_wvalid_i;
    assign rd_cand = s_axi_arvalid_i;
    assign full    = (count_q == cnt_w'(els_p));

    // Round-robin choice among present candidates, then check the chosen one can go.
    assign sel_rd   = rd_cand & (~wr_cand | rd_prio_q);
    assign sel_wr   = wr_cand & ~sel_rd;
    assign rd_grant = reset_n_i & sel_rd & ~full & (rd_oor | ready_i);
    assign wr_grant = reset_n_i & sel_wr & ~full & (wr_oor | ready_i);
    assign push      = rd_grant | wr_grant;
    assign grant_err = rd_grant ? rd_oor : wr_oor;

    assign s_axi_awready_o = wr_grant;
    assign s_axi_wready_o  = wr_grant;
    assign s_axi_arready_o = rd_grant;
    assign v_o             = push & ~grant_err;

    always_comb begin
        data_o = '0;
        if (v_o && wr_grant)
            data_o = {1'b1, s_axi_awaddr_i[pkt_addr_width_p-1:0], s_axi_wdata_i[pkt_data_width_p-1:0]};
        else if (v_o)
            data_o = {1'b0, s_axi_araddr_i[pkt_addr_width_p-1:0], {pkt_data_width_p{1'b0}}};
    end

    assign nonempty   = reset_n_i & (count_q != '0);
    assign head_w     = fifo_q[rd_ptr_q][1];
    assign head_err   = fifo_q[rd_ptr_q][0];
    assign head_rd_ok = nonempty & ~head_w & ~head_err;

    assign s_axi_bvalid_o = nonempty & head_w;
    assign s_axi_bresp_o  = (nonempty & head_w & head_err) ? resp_slverr : resp_okay;
    assign s_axi_rvalid_o = nonempty & ~head_w & (head_err | v_i);
    assign s_axi_rresp_o  = (nonempty & ~head_w & head_err) ? resp_slverr : resp_okay;
    assign s_axi_rdata_o  = (head_rd_ok & v_i) ? data_i : '0;
    assign ready_o        = head_rd_ok & s_axi_rready_i;

    assign pop = (s_axi_bvalid_o & s_axi_bready_i) | (s_axi_rvalid_o & s_axi_rready_i);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_prio_d = rd_prio_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + ptr_w'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + ptr_w'(1);
        if (push && !pop)
            count_d = count_q + cnt_w'(1);
        else if (pop && !push)
            count_d = count_q - cnt_w'(1);
        if (rd_grant)
            rd_prio_d = 1'b0;
        else if (wr_grant)
            rd_prio_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_prio_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_prio_q <= rd_prio_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            fifo_q[wr_ptr_q] <= {wr_grant, grant_err};
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot_i, s_axi_arprot_i, s_axi_wstrb_i, s_axi_wdata_i};

endmodule

// File: tb/tb_bsg_axil_packet_packer.sv
// tb/tb_bsg_axil_packet_packer.sv - directed scoreboard bench for bsg_axil_packet_packer
module tb_bsg_axil_packet_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] awaddr, wdata, araddr, rdata, dout_rd, data_in;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready;
    logic        rvalid, rready, v_o, ready_i, v_i, ready_o;
    logic [1:0]  bresp, rresp;
    logic [31:0] data_o;

    typedef struct {
        logic        is_w;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bsg_axil_packet_packer dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .s_axi_awaddr_i(awaddr), .s_axi_awprot_i(awprot), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
        .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
        .s_axi_araddr_i(araddr), .s_axi_arprot_i(arprot), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
        .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
        .data_i(data_in), .v_i(v_i), .ready_o(ready_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awaddr = '0; wdata = '0; araddr = '0; awprot = 3'd5; arprot = 3'd3; wstrb = 4'h0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        ready_i = 0; v_i = 0; data_in = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        sb.delete();
    endtask

    task automatic drain_one();
        exp_t e;
        int   n;
        e = sb.pop_front();
        bready = 1; rready = 1; v_i = 1;
        data_in = (!e.is_w && e.resp == 2'b00) ? e.data : 32'hBAD0_BAD0;
        n = 0;
        #4;
        while (!(bvalid | rvalid) && n < 20) begin
            tick();
            #4;
            n++;
        end
        chk("resp_valid", {63'd0, bvalid | rvalid}, 64'd1);
        chk("resp_kind_is_write", {63'd0, bvalid}, {63'd0, e.is_w});
        if (e.is_w) begin
            chk("bresp", {62'd0, bresp}, {62'd0, e.resp});
        end else begin
            chk("rresp", {62'd0, rresp}, {62'd0, e.resp});
            chk("rdata", {32'd0, rdata}, {32'd0, (e.resp == 2'b00) ? e.data : 32'd0});
            chk("ready_o", {63'd0, ready_o}, {63'd0, e.resp == 2'b00});
        end
        tick();
        bready = 0; rready = 0; v_i = 0; data_in = '0;
    endtask

    logic exp_rd [4];

    initial begin
        exp_t e;
        idle_inputs();
        reset_n = 0;
        tick();
        awvalid = 1; wvalid = 1; arvalid = 1; ready_i = 1; awaddr = 32'h10; araddr = 32'h20;
        #4;
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_v_o", {63'd0, v_o}, 64'd0);
        chk("rst_data_o", {32'd0, data_o}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_ready_o", {63'd0, ready_o}, 64'd0);
        chk("rst_resp", {60'd0, bresp, rresp}, 64'd0);
        tick();
        idle_inputs();
        reset_n = 1;

        // Single in-range write.
        awvalid = 1; wvalid = 1; awaddr = 32'h0000_1234; wdata = 32'hFFFF_FFAB; ready_i = 1; wstrb = 4'hF;
        #4;
        chk("wr_v_o", {63'd0, v_o}, 64'd1);
        chk("wr_data_o", {32'd0, data_o}, 64'h8012_34AB);
        chk("wr_awready", {63'd0, awready}, 64'd1);
        chk("wr_wready", {63'd0, wready}, 64'd1);
        chk("wr_no_bypass", {63'd0, bvalid}, 64'd0);
        sb.push_back('{is_w: 1'b1, resp: 2'b00, data: 32'd0});
        tick();
        idle_inputs();
        drain_one();
        #4;
        chk("wr_bvalid_cleared", {63'd0, bvalid}, 64'd0);
        tick();

        // Single in-range read.
        arvalid = 1; araddr = 32'h0000_0010; ready_i = 1;
        #4;
        chk("rd_v_o", {63'd0, v_o}, 64'd1);
        chk("rd_data_o", {32'd0, data_o}, 64'h0000_1000);
        chk("rd_arready", {63'd0, arready}, 64'd1);
        sb.push_back('{is_w: 1'b0, resp: 2'b00, data: 32'hDEAD_BEEF});
        tick();
        idle_inputs();
        #4;
        chk("rd_rvalid_waits_v_i", {63'd0, rvalid}, 64'd0);
        tick();
        drain_one();

        // Contending reads and writes from reset: R,W,R,W then full.
        do_reset();
        exp_rd = '{1'b1, 1'b0, 1'b1, 1'b0};
        awvalid = 1; wvalid = 1; arvalid = 1; ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            araddr = 32'h100 + i; awaddr = 32'h200 + i; wdata = 32'h30 + i;
            #4;
            chk("rr_arready", {63'd0, arready}, {63'd0, exp_rd[i]});
            chk("rr_awready", {63'd0, awready}, {63'd0, !exp_rd[i]});
            chk("rr_v_o", {63'd0, v_o}, 64'd1);
            chk("rr_data_o", {32'd0, data_o},
                {32'd0, exp_rd[i] ? {1'b0, 23'(32'h100 + i), 8'h00} : {1'b1, 23'(32'h200 + i), 8'(32'h30 + i)}});
            sb.push_back('{is_w: !exp_rd[i], resp: 2'b00, data: 32'hC0DE_0000 + i});
            tick();
        end
        rready = 1; v_i = 1; data_in = sb[0].data;
        #4;
        chk("full_arready", {63'd0, arready}, 64'd0);
        chk("full_awready", {63'd0, awready}, 64'd0);
        chk("full_v_o", {63'd0, v_o}, 64'd0);
        chk("full_head_rvalid", {63'd0, rvalid}, 64'd1);
        e = sb.pop_front();
        chk("full_head_rdata", {32'd0, rdata}, {32'd0, e.data});
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) drain_one();

        // Out-of-range read then in-range write; ready_i low must not stall the error read.
        arvalid = 1; araddr = 32'h0080_0000; ready_i = 0;
        #4;
        chk("oor_arready", {63'd0, arready}, 64'd1);
        chk("oor_v_o", {63'd0, v_o}, 64'd0);
        chk("oor_data_o", {32'd0, data_o}, 64'd0);
        sb.push_back('{is_w: 1'b0, resp: 2'b10, data: 32'd0});
        tick();
        idle_inputs();
        awvalid = 1; wvalid = 1; awaddr = 32'h1; wdata = 32'h5A; ready_i = 1;
        #4;
        chk("oor_wr_data_o", {32'd0, data_o}, 64'h8000_015A);
        sb.push_back('{is_w: 1'b1, resp: 2'b00, data: 32'd0});
        tick();
        idle_inputs();
        drain_one();
        drain_one();

        // Backpressure from the packet sink holds an in-range write.
        awvalid = 1; wvalid = 1; awaddr = 32'h0000_4444; wdata = 32'h77; ready_i = 0;
        for (int i = 0; i < 2; i++) begin
            #4;
            chk("bp_awready", {63'd0, awready}, 64'd0);
            chk("bp_wready", {63'd0, wready}, 64'd0);
            chk("bp_v_o", {63'd0, v_o}, 64'd0);
            tick();
        end
        ready_i = 1;
        #4;
        chk("bp_release_v_o", {63'd0, v_o}, 64'd1);
        chk("bp_release_data_o", {32'd0, data_o}, 64'h8044_4477);
        sb.push_back('{is_w: 1'b1, resp: 2'b00, data: 32'd0});
        tick();
        awaddr = 32'hFF00_0000; ready_i = 0;
        #4;
        chk("oor_wr_awready", {63'd0, awready}, 64'd1);
        chk("oor_wr_v_o", {63'd0, v_o}, 64'd0);
        sb.push_back('{is_w: 1'b1, resp: 2'b10, data: 32'd0});
        tick();
        idle_inputs();
        drain_one();
        drain_one();

        // Reset with two reads outstanding drops them.
        arvalid = 1; araddr = 32'h40; ready_i = 1;
        tick();
        araddr = 32'h44;
        tick();
        idle_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
        sb.delete();
        rready = 1; v_i = 1; data_in = 32'h1357_9BDF;
        #4;
        chk("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("post_rst_ready_o", {63'd0, ready_o}, 64'd0);
        chk("post_rst_bvalid", {63'd0, bvalid}, 64'd0);
        tick();
        idle_inputs();
        awvalid = 1; wvalid = 1; awaddr = 32'h0000_0002; wdata = 32'h11; ready_i = 1;
        #4;
        chk("post_rst_wr_v_o", {63'd0, v_o}, 64'd1);
        chk("post_rst_wr_data_o", {32'd0, data_o}, 64'h8000_0211);
        sb.push_back('{is_w: 1'b1, resp: 2'b00, data: 32'd0});
        tick();
        idle_inputs();
        drain_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_axil_packet_packer.md
BSG_AXIL_PACKET_PACKER -- requirements
Module: bsg_axil_packet_packer

Interface
REQ-001 SHALL have parameter axi_addr_width_p, default 32, AXI-lite address width.
REQ-002 SHALL have parameter axi_data_width_p, default 32, AXI-lite data width and return-data width.
REQ-003 SHALL have parameter pkt_addr_width_p, default 23, packet address field width.
REQ-004 SHALL have parameter pkt_data_width_p, default 8, packet write-data field width (<= axi_data_width_p).
REQ-005 SHALL have parameter els_p, default 4, maximum outstanding requests (>= 1).
REQ-006 SHALL derive pkt_width_p = 1 + pkt_addr_width_p + pkt_data_width_p.
REQ-007 SHALL have ports clk_i  in  1  clock; reset_n_i  in  1  reset: one clock, synchronous, active-low.
REQ-008 SHALL have AXI-lite slave ports s_axi_aw{addr,prot,valid,ready}, s_axi_w{data,strb,valid,ready}, s_axi_b{resp,valid,ready}, s_axi_ar{addr,prot,valid,ready}, s_axi_r{data,resp,valid,ready}, with standard widths and directions.
REQ-009 SHALL have data_o  out  pkt_width_p  packet {write_not_read, addr, data}; v_o  out  1; ready_i  in  1.
REQ-010 SHALL have data_i  in  axi_data_width_p  read return; v_i  in  1; ready_o  out  1.

Function
REQ-011 Read packet SHALL be {0, araddr[pkt_addr_width_p-1:0], zeros}; write packet SHALL be {1, awaddr[pkt_addr_width_p-1:0], wdata[pkt_data_width_p-1:0]}.
REQ-012 Request is in-range iff address bits [axi_addr_width_p-1:pkt_addr_width_p] are all zero; out-of-range requests SHALL emit no packet.
REQ-013 Write candidate = awvalid & wvalid; read candidate = arvalid; read and write SHALL NOT be required to be mutually exclusive.
REQ-014 Both candidates present -> round-robin grant; after reset, read has priority; after each grant, priority goes to the other type.
REQ-015 Grant SHALL require order queue not full AND (request out-of-range OR ready_i); full blocks acceptance even if a response dequeues that same cycle.
REQ-016 On write grant, awready and wready SHALL both assert in that cycle; on read grant, arready SHALL assert; no ready is asserted otherwise.
REQ-017 v_o SHALL assert only in a cycle with an in-range grant; data_o SHALL be '0 when v_o is low.
REQ-018 Each grant SHALL push {is_write, err} into an in-order queue of depth els_p; responses SHALL be returned strictly in grant order.
REQ-019 Head = write: bvalid=1, bresp = err ? SLVERR : OKAY; pop on bvalid & bready.
REQ-020 Head = read, err=0: rvalid = v_i, rdata = data_i, rresp = OKAY, ready_o = rready_i; pop on rvalid & rready.
REQ-021 Head = read, err=1: rvalid=1, rdata='0, rresp=SLVERR, ready_o=0 (data_i not consumed); pop on rvalid & rready.
REQ-022 ready_o SHALL be 0 whenever queue empty or head is not an in-range read.
REQ-023 Minimum latency grant -> response valid SHALL be 1 cycle (no same-cycle bypass).
REQ-024 Outstanding count SHALL never exceed els_p; push and pop in same cycle (not full) SHALL leave count unchanged.
REQ-025 wstrb and prot SHALL be ignored.

Reset
REQ-026 While reset_n_i=0 at a clock edge: queue empties, count=0, read priority set.
REQ-027 During and after reset all valid/ready outputs SHALL be 0 except as granted by REQ-015/016 once reset_n_i=1; resp outputs OKAY, data outputs '0.
REQ-028 Reset mid-transaction SHALL drop all outstanding entries; no B/R response is issued for them.

Verification
REQ-029 Write awaddr=0x0000_1234, wdata=0xAB, ready_i=1 -> data_o=0x8012_34AB, v_o=1 same cycle; bvalid next cycle, bresp OKAY.
REQ-030 Read araddr=0x0000_0010, then v_i=1 data_i=0xDEAD_BEEF -> data_o=0x0000_1000; rdata=0xDEAD_BEEF, rresp OKAY, ready_o=rready_i.
REQ-031 aw/w/ar all valid for 4 cycles, ready_i=1, responses held off -> grants alternate R,W,R,W; 5th request stalled (els_p=4); responses in same order.
REQ-032 araddr=0x0080_0000 -> no v_o; rvalid next cycle, rdata=0, rresp SLVERR, ready_o=0; later write to 0x1 then OKAY in order.
REQ-033 ready_i=0 with valid in-range write -> awready=wready=0, v_o=0 until ready_i=1.
REQ-034 Two reads outstanding, reset_n_i=0 one cycle -> rvalid=0, ready_o=0 afterwards; new request accepted normally.
